branch_resolve_predict: RTL
===========================

// Module: branch_resolve_predict
// PURPOSE
//  Parametrised successor to the EX-stage branch comparator. Resolves all six RV64 conditional
//  branches (signed and unsigned) and drives the PC-adder mux select. Adds a direct-mapped
//  table of 2-bit saturating counters (BHT) that predicts at IF and trains at EX.
//  Flags mispredictions for pipeline flush and keeps saturating branch/mispredict counts.
// PARAMETERS
//  XLEN        64  operand and PC width
//  BHT_ENTRIES 64  number of predictor entries; power of 2, >=2; IDX_W = $clog2(BHT_ENTRIES)
//  CNT_W       32  width of the statistics counters
// PORTS
//  clk              in   1      rising-edge clock
//  reset_n          in   1      asynchronous, active-low reset
//  if_pc_i          in   XLEN   IF-stage PC, used for lookup
//  if_pred_taken_o  out  1      prediction: MSB of BHT[idx(if_pc_i)]
//  ex_valid_i       in   1      EX stage holds a valid instruction
//  ex_is_branch_i   in   1      EX instruction is a conditional branch
//  ex_pc_i          in   XLEN   PC of the EX instruction, used for training
//  funct3_i         in   3      branch type
//  rs1_i            in   XLEN   readData1
//  rs2_i            in   XLEN   second operand (b)
//  ex_pred_taken_i  in   1      prediction made at IF, piped down with the instruction
//  taken_o          out  1      resolved outcome; PC-adder mux select
//  mispredict_o     out  1      resolved outcome != ex_pred_taken_i
//  illegal_o        out  1      branch with unsupported funct3
//  branch_cnt_o     out  CNT_W  number of resolved branches, saturating
//  mispred_cnt_o    out  CNT_W  number of mispredictions, saturating
// BEHAVIOUR
//  - Index: idx(pc) = pc[IDX_W+1:2].
//  - Resolution is combinational, with zero latency:
//    - 000 BEQ:  rs1 == rs2
//    - 001 BNE:  rs1 != rs2
//    - 100 BLT:  signed <
//    - 101 BGE:  signed >=
//    - 110 BLTU: unsigned <
//    - 111 BGEU: unsigned >=
//  - funct3 010 and 011: taken_o = 0, illegal_o = 1.
//  - Qualifier res = ex_valid_i & ex_is_branch_i & legal funct3.
//    - When res = 0: taken_o = 0, mispredict_o = 0, illegal_o = 0 (except illegal_o as above).
//    - When res = 1: mispredict_o = taken_o ^ ex_pred_taken_i.
//  - Outputs never hold a stale value: every combinational output is fully assigned on every path.
//  - Training happens on the clk edge when res = 1, on BHT[idx(ex_pc_i)]:
//    - taken: counter +1, saturating at 2'b11
//    - not taken: counter -1, saturating at 2'b00
//  - Counter states:
//    - 00 strong-not-taken
//    - 01 weak-not-taken
//    - 10 weak-taken
//    - 11 strong-taken
//  - Lookup and training in the same cycle:
//    - Same index: if_pred_taken_o shows the pre-update value; there is no bypass.
//    - Different indices: independent.
//  - Statistics, on the clk edge:
//    - res = 1: branch_cnt_o += 1.
//    - res & mispredict_o: mispred_cnt_o += 1.
//    - Both hold at all-ones and never wrap.
//  - Reset (asynchronous, any time including mid-training):
//    - Every BHT entry goes to 2'b01, so if_pred_taken_o = 0.
//    - Both counters go to 0.
//    - A training write pending in that cycle is discarded.
//    - Combinational outputs keep following their inputs.
//  - The table is flops, not a RAM. Read is combinational; write is synchronous.
// STRUCTURE
//  - Shared package branch_pkg:
//    - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
//    - counter constants CTR_SNT, CTR_WNT, CTR_WT, CTR_ST
//    - function sat_update(ctr, taken)
//  - One sub-module, bp_bht: the counter array with its index, lookup and update logic,
//    parametrised by BHT_ENTRIES.
//  - Comparator and statistics counters live in the top.
// TESTING
//  1. BLT, rs1 = -1 (all ones), rs2 = 1 -> taken_o = 1. Same operands with BLTU -> taken_o = 0.
//  2. BGE and BGEU with rs1 = rs2 = 64'h5 -> taken_o = 1. BNE with the same operands -> taken_o = 0.
//  3. funct3 = 3'b010 with res inputs high -> illegal_o = 1, taken_o = 0; no BHT or counter change.
//  4. Three taken branches at PC 0x100 after reset; if_pc_i = 0x100 after each edge:
//     - prediction sequence 1, 1, 1
//     - entry ends at 11
//     - two not-taken branches then leave it at 01, so predict = 0
//  5. Train at PC 0x100 with taken, and in the same cycle look up 0x100 from entry 01
//     -> if_pred_taken_o = 0 that cycle, 1 the next.
//  6. Preload mispred_cnt_o to all-ones (force), then mispredict -> value holds.
//     Assert reset_n low between edges -> counters read 0 and if_pred_taken_o = 0
//     immediately, before the next edge.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolver and its bimodal predictor.
package branch_pkg;

    // Conditional-branch funct3 encodings (RV64I B-type)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Two-bit saturating counter; the MSB is the taken prediction
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;  // strong not-taken
    localparam ctr_t CTR_WNT = 2'b01;  // weak not-taken (reset value)
    localparam ctr_t CTR_WT  = 2'b10;  // weak taken
    localparam ctr_t CTR_ST  = 2'b11;  // strong taken

    // Move a counter one step towards the observed outcome, holding at either end
    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

    // 010 and 011 are not branch encodings
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/bp_bht.sv
// Direct-mapped table of 2-bit saturating counters: combinational lookup at IF,
// synchronous training at EX. Lookup never bypasses a same-cycle write.
module bp_bht
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_taken_o,
    input  logic            train_en_i,
    input  logic [XLEN-1:0] train_pc_i,
    input  logic            train_taken_i
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("bp_bht: BHT_ENTRIES must be a power of two and at least 2");
    end

    ctr_t             bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] train_idx;
    ctr_t             lookup_ctr;
    ctr_t             train_ctr;

    // Instructions are word aligned, so the two LSBs carry no index information
    assign lookup_idx = lookup_pc_i[IDX_W+1:2];
    assign train_idx  = train_pc_i[IDX_W+1:2];

    // PC bits outside the index field do not take part in the lookup
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0],
                              train_pc_i[XLEN-1:IDX_W+2], train_pc_i[1:0]};

    // Read both addressed entries from the current (pre-update) table contents
    always_comb begin
        lookup_ctr   = bht_q[lookup_idx];
        train_ctr    = bht_q[train_idx];
        pred_taken_o = lookup_ctr[1];
    end

    // Counter array: reset to weak not-taken, one entry trained per resolved branch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= CTR_WNT;
            end
        end else if (train_en_i) begin
            bht_q[train_idx] <= sat_update(train_ctr, train_taken_i);
        end
    end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with a bimodal predictor. Resolves the six RV64
// conditional branches, flags mispredictions and keeps saturating statistics.
module branch_resolve_predict
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic             ex_pred_taken_i,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic             is_eq;
    logic             is_lt_s;
    logic             is_lt_u;
    logic             cond;
    logic             legal;
    logic             branch_seen;
    logic             res;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    assign is_eq   = (rs1_i == rs2_i);
    assign is_lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign is_lt_u = (rs1_i < rs2_i);

    // Select the raw branch condition for the funct3 encoding
    always_comb begin
        cond = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond = is_eq;
            F3_BNE:  cond = ~is_eq;
            F3_BLT:  cond = is_lt_s;
            F3_BGE:  cond = ~is_lt_s;
            F3_BLTU: cond = is_lt_u;
            F3_BGEU: cond = ~is_lt_u;
            default: cond = 1'b0;
        endcase
    end

    // Qualify the outcome; nothing leaves this block unless a real branch resolves
    always_comb begin
        legal        = f3_is_legal(funct3_i);
        branch_seen  = ex_valid_i & ex_is_branch_i;
        res          = branch_seen & legal;
        taken_o      = res & cond;
        mispredict_o = res & (cond ^ ex_pred_taken_i);
        illegal_o    = branch_seen & ~legal;
    end

    bp_bht #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_pc_i   (if_pc_i),
        .pred_taken_o  (if_pred_taken_o),
        .train_en_i    (res),
        .train_pc_i    (ex_pc_i),
        .train_taken_i (taken_o)
    );

    // Statistics counters, each holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (mispredict_o && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
